// File: rtl/sprite_pixel_reader.sv
// Sprite pixel reader: queues pixel requests, fetches palette indices from a 16-bit
// sprite memory through a one-word cache, and presents results in request order.
module sprite_pixel_reader #(
  parameter int         ADDR_W      = 21,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] TRANSPARENT = 8'h00
) (
  input  logic              frame_Clk,
  input  logic              Reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              spriteOn,
  input  logic [ADDR_W-1:0] spriteAddress,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              mem_rd,
  output logic [ADDR_W-2:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_color,
  output logic              out_opaque,
  output logic [9:0]        out_X,
  output logic [9:0]        out_Y
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_W + 21;

  typedef enum logic [1:0] {IDLE, READ, EMIT} ReaderState;

  ReaderState state, nextState;

  logic [ENTRY_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic [PTR_W:0]     fifoCount;
  logic               fifoFull, fifoEmpty, push, pop;

  logic              headOn;
  logic [ADDR_W-1:0] headAddr;
  logic [9:0]        headX, headY;
  logic [ADDR_W-2:0] headWord;

  logic              cacheValid;
  logic [ADDR_W-2:0] cacheTag;
  logic [15:0]       cacheWord;
  logic              cacheHit;

  logic        loadOut, startRead, newFrame;
  logic [15:0] srcWord;
  logic [7:0]  selByte, loadColor;

  assign fifoFull  = (fifoCount == (PTR_W+1)'(FIFO_DEPTH));
  assign fifoEmpty = (fifoCount == '0);
  assign pix_ready = !fifoFull;
  assign push      = pix_valid && pix_ready;

  assign {headOn, headAddr, headX, headY} = fifoMem[rdPtr];
  assign headWord = headAddr[ADDR_W-1:1];
  assign cacheHit = cacheValid && (cacheTag == headWord);

  // A request at the frame origin means the sprite ROM may have switched bank.
  assign newFrame = push && (DrawX == '0) && (DrawY == '0);

  always_ff @(posedge frame_Clk) begin
    if (push)
      fifoMem[wrPtr] <= {spriteOn, spriteAddress, DrawX, DrawY};
  end

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push)
        wrPtr <= wrPtr + PTR_W'(1);
      if (pop)
        rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + (PTR_W+1)'(1);
        2'b01:   fifoCount <= fifoCount - (PTR_W+1)'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge frame_Clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    loadOut   = 1'b0;
    startRead = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          if (!headOn || cacheHit) begin
            pop       = 1'b1;
            loadOut   = 1'b1;
            nextState = EMIT;
          end else begin
            startRead = 1'b1;
            nextState = READ;
          end
        end
      end
      READ: begin
        if (mem_ack) begin
          pop       = 1'b1;
          loadOut   = 1'b1;
          nextState = EMIT;
        end
      end
      EMIT: begin
        if (out_ready)
          nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == EMIT);
    mem_rd    = (state == READ);
  end

  // In READ the head pixel comes straight off the memory bus; otherwise from the cache.
  always_comb begin
    srcWord   = (state == READ) ? mem_data : cacheWord;
    selByte   = headAddr[0] ? srcWord[15:8] : srcWord[7:0];
    loadColor = headOn ? selByte : TRANSPARENT;
  end

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      mem_addr   <= '0;
      out_color  <= '0;
      out_opaque <= 1'b0;
      out_X      <= '0;
      out_Y      <= '0;
      cacheValid <= 1'b0;
      cacheTag   <= '0;
      cacheWord  <= '0;
    end else begin
      if (startRead)
        mem_addr <= headWord;
      if (loadOut) begin
        out_color  <= loadColor;
        out_opaque <= headOn && (loadColor != TRANSPARENT);
        out_X      <= headX;
        out_Y      <= headY;
      end
      if ((state == READ) && mem_ack) begin
        cacheWord  <= mem_data;
        cacheTag   <= headWord;
        cacheValid <= 1'b1;
      end
      // Invalidation wins over a same-cycle fill so the new frame never sees old data.
      if (newFrame)
        cacheValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Bench for sprite_pixel_reader: a result model fed from accepted requests, a memory
// responder with configurable wait states, and directed scenarios with literal checks.
module tb_sprite_pixel_reader;

  localparam int ADDR_W = 21;
  localparam int DEPTH  = 4;

  logic        frame_Clk, Reset;
  logic        pix_valid, pix_ready, spriteOn;
  logic [20:0] spriteAddress;
  logic [9:0]  DrawX, DrawY;
  logic        mem_rd, mem_ack;
  logic [19:0] mem_addr;
  logic [15:0] mem_data;
  logic        out_valid, out_ready, out_opaque;
  logic [7:0]  out_color;
  logic [9:0]  out_X, out_Y;

  typedef struct {
    logic [7:0] color;
    logic       opaque;
    logic [9:0] x;
    logic [9:0] y;
  } Result;

  Result expQ[$];
  Result seenQ[$];
  Result expR, heldRes, curRes;

  int checks = 0;
  int fails = 0;
  int rdCount = 0;
  int rdCycles = 0;
  int memEnable, ackDelay, strayReq, strayDone, waitCnt;
  logic        prevHeld, prevMemRd;
  logic [19:0] prevAddr, lastRdAddr;

  sprite_pixel_reader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .TRANSPARENT(8'h00)) dut (
    .frame_Clk(frame_Clk), .Reset(Reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .spriteOn(spriteOn), .spriteAddress(spriteAddress), .DrawX(DrawX), .DrawY(DrawY),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_color(out_color),
    .out_opaque(out_opaque), .out_X(out_X), .out_Y(out_Y)
  );

  initial begin
    frame_Clk = 1'b0;
    forever #5 frame_Clk = ~frame_Clk;
  end

  // Sprite memory contents: two hand-picked words, everything else a simple pattern.
  function automatic logic [15:0] memWord(input logic [19:0] w);
    case (w)
      20'd5:   return 16'hAB12;
      20'd6:   return 16'h3400;
      default: return {~w[7:0], w[7:0] + 8'h20};
    endcase
  endfunction

  function automatic Result model(input logic on, input logic [20:0] addr,
                                  input logic [9:0] x, input logic [9:0] y);
    Result r;
    logic [15:0] word;
    word = memWord(addr[20:1]);
    if (!on)
      r.color = 8'h00;
    else
      r.color = addr[0] ? word[15:8] : word[7:0];
    r.opaque = on && (r.color != 8'h00);
    r.x = x;
    r.y = y;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Memory responder: acks after ackDelay wait cycles, or injects one stray ack on request.
  initial begin
    mem_ack = 1'b0;
    mem_data = 16'h0000;
    waitCnt = 0;
    strayDone = 0;
    forever begin
      @(posedge frame_Clk);
      #1;
      mem_ack = 1'b0;
      if (strayReq != strayDone) begin
        mem_ack = 1'b1;
        mem_data = 16'hFFFF;
        strayDone = strayReq;
      end else if (memEnable != 0 && mem_rd) begin
        if (waitCnt >= ackDelay) begin
          mem_ack = 1'b1;
          mem_data = memWord(mem_addr);
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge frame_Clk) begin
    if (Reset) begin
      expQ.delete();
      prevHeld = 1'b0;
      prevMemRd = 1'b0;
    end else begin
      if (pix_valid && pix_ready)
        expQ.push_back(model(spriteOn, spriteAddress, DrawX, DrawY));
      if (mem_rd)
        rdCycles++;
      if (mem_rd && !prevMemRd) begin
        rdCount++;
        lastRdAddr = mem_addr;
      end
      if (mem_rd && prevMemRd)
        checkOutput("mem_addr_stable", mem_addr, prevAddr);
      prevMemRd = mem_rd;
      prevAddr = mem_addr;
      curRes.color = out_color;
      curRes.opaque = out_opaque;
      curRes.x = out_X;
      curRes.y = out_Y;
      if (out_valid) begin
        if (prevHeld) begin
          checkOutput("held_color", out_color, heldRes.color);
          checkOutput("held_x", out_X, heldRes.x);
        end
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_result: out_valid with no pending request, X=%0d", out_X);
        end else if (out_ready) begin
          expR = expQ.pop_front();
          checkOutput("color", out_color, expR.color);
          checkOutput("opaque", out_opaque, expR.opaque);
          checkOutput("out_X", out_X, expR.x);
          checkOutput("out_Y", out_Y, expR.y);
          seenQ.push_back(curRes);
        end
      end
      prevHeld = out_valid && !out_ready;
      heldRes = curRes;
    end
  end

  task automatic applyStimulus(input logic on, input logic [20:0] addr,
                               input logic [9:0] x, input logic [9:0] y);
    int n;
    n = 0;
    spriteOn = on;
    spriteAddress = addr;
    DrawX = x;
    DrawY = y;
    pix_valid = 1'b1;
    do begin
      @(negedge frame_Clk);
      n++;
    end while (!pix_ready && n < 200);
    if (!pix_ready) begin
      fails++;
      $display("[TB] FAIL accept_timeout: pix_ready=%0b, required 1", pix_ready);
    end
    @(posedge frame_Clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 500) begin
      @(negedge frame_Clk);
      n++;
    end
    if (n >= 500) begin
      fails++;
      $display("[TB] FAIL drain_timeout: %0d results pending, required 0", expQ.size());
    end
    @(posedge frame_Clk);
    #1;
  endtask

  task automatic checkIdleZero(input string tag);
    @(negedge frame_Clk);
    checkOutput({tag, "_pix_ready"}, pix_ready, 1);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_mem_rd"}, mem_rd, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_out_color"}, out_color, 0);
    checkOutput({tag, "_out_opaque"}, out_opaque, 0);
    checkOutput({tag, "_out_X"}, out_X, 0);
    checkOutput({tag, "_out_Y"}, out_Y, 0);
    @(posedge frame_Clk);
    #1;
  endtask

  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    int r0, c0, acc, n;
    logic took;
    Reset = 1'b1;
    pix_valid = 1'b0;
    spriteOn = 1'b0;
    spriteAddress = '0;
    DrawX = 10'd1;
    DrawY = 10'd1;
    out_ready = 1'b1;
    memEnable = 1;
    ackDelay = 0;
    strayReq = 0;
    repeat (3) @(posedge frame_Clk);
    #1;
    Reset = 1'b0;
    checkIdleZero("reset");

    // Miss on word 5 fills the cache, neighbouring byte then hits.
    seenQ.delete();
    r0 = rdCount;
    applyStimulus(1'b1, 21'd10, 10'd1, 10'd2);
    applyStimulus(1'b1, 21'd11, 10'd2, 10'd2);
    waitDrain();
    checkOutput("miss_hit_reads", rdCount - r0, 1);
    checkOutput("miss_hit_addr", lastRdAddr, 20'd5);
    checkOutput("miss_hit_count", seenQ.size(), 2);
    if (seenQ.size() == 2) begin
      checkOutput("miss_color", seenQ[0].color, 8'h12);
      checkOutput("miss_opaque", seenQ[0].opaque, 1);
      checkOutput("hit_color", seenQ[1].color, 8'hAB);
      checkOutput("hit_opaque", seenQ[1].opaque, 1);
    end

    // Outside the sprite box: no memory traffic.
    seenQ.delete();
    r0 = rdCount;
    applyStimulus(1'b0, 21'd77, 10'd100, 10'd50);
    waitDrain();
    checkOutput("outside_reads", rdCount - r0, 0);
    checkOutput("outside_count", seenQ.size(), 1);
    if (seenQ.size() == 1) begin
      checkOutput("outside_color", seenQ[0].color, 8'h00);
      checkOutput("outside_opaque", seenQ[0].opaque, 0);
      checkOutput("outside_X", seenQ[0].x, 10'd100);
    end

    // Transparent byte on a cache hit.
    seenQ.delete();
    r0 = rdCount;
    applyStimulus(1'b1, 21'd13, 10'd3, 10'd4);
    applyStimulus(1'b1, 21'd12, 10'd4, 10'd4);
    waitDrain();
    checkOutput("transp_reads", rdCount - r0, 1);
    checkOutput("transp_count", seenQ.size(), 2);
    if (seenQ.size() == 2) begin
      checkOutput("odd_color", seenQ[0].color, 8'h34);
      checkOutput("odd_opaque", seenQ[0].opaque, 1);
      checkOutput("transp_color", seenQ[1].color, 8'h00);
      checkOutput("transp_opaque", seenQ[1].opaque, 0);
    end

    // Frame origin request invalidates the cache.
    r0 = rdCount;
    applyStimulus(1'b1, 21'd12, 10'd5, 10'd5);
    waitDrain();
    checkOutput("still_cached_reads", rdCount - r0, 0);
    r0 = rdCount;
    applyStimulus(1'b0, 21'd0, 10'd0, 10'd0);
    applyStimulus(1'b1, 21'd12, 10'd6, 10'd5);
    waitDrain();
    checkOutput("new_frame_reads", rdCount - r0, 1);

    // Back-pressure: one result parked at the output, DEPTH more queued behind it.
    seenQ.delete();
    out_ready = 1'b0;
    spriteOn = 1'b0;
    spriteAddress = '0;
    DrawX = 10'd200;
    DrawY = 10'd7;
    pix_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge frame_Clk);
      took = pix_ready;
      if (took)
        acc++;
      @(posedge frame_Clk);
      #1;
      if (took)
        DrawX = DrawX + 10'd1;
    end
    pix_valid = 1'b0;
    @(negedge frame_Clk);
    checkOutput("bp_accepted", acc, DEPTH + 1);
    checkOutput("bp_pix_ready", pix_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_parked_X", out_X, 10'd200);
    @(posedge frame_Clk);
    #1;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("bp_count", seenQ.size(), DEPTH + 1);
    for (int i = 0; i < seenQ.size(); i++)
      checkOutput("bp_order", seenQ[i].x, 200 + i);

    // Slow memory: seven wait cycles before the ack.
    ackDelay = 7;
    seenQ.delete();
    r0 = rdCount;
    c0 = rdCycles;
    applyStimulus(1'b1, 21'd100, 10'd9, 10'd9);
    waitDrain();
    ackDelay = 0;
    checkOutput("slow_reads", rdCount - r0, 1);
    checkOutput("slow_rd_cycles", rdCycles - c0, 8);
    checkOutput("slow_addr", lastRdAddr, 20'd50);
    checkOutput("slow_count", seenQ.size(), 1);
    if (seenQ.size() == 1)
      checkOutput("slow_color", seenQ[0].color, 8'h52);

    // Reset during READ, then a late ack that must be ignored.
    memEnable = 0;
    applyStimulus(1'b1, 21'd40, 10'd3, 10'd3);
    n = 0;
    do begin
      @(negedge frame_Clk);
      n++;
    end while (!mem_rd && n < 50);
    checkOutput("rst_read_started", mem_rd, 1);
    repeat (2) @(posedge frame_Clk);
    #1;
    Reset = 1'b1;
    @(posedge frame_Clk);
    #1;
    Reset = 1'b0;
    strayReq++;
    repeat (3) @(posedge frame_Clk);
    #1;
    checkIdleZero("midread_reset");
    memEnable = 1;
    seenQ.delete();
    r0 = rdCount;
    applyStimulus(1'b1, 21'd40, 10'd4, 10'd4);
    waitDrain();
    checkOutput("post_reset_reads", rdCount - r0, 1);
    checkOutput("post_reset_count", seenQ.size(), 1);
    if (seenQ.size() == 1)
      checkOutput("post_reset_color", seenQ[0].color, 8'h34);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
